multicycle_controller: RTL and testbench

//  Control FSM for the multi-cycle RV32I core. It shares one ALU and one unified memory across fetch, execute and writeback.

---
 rtl/rv_ctrl_pkg.sv | 158 +++++++++++++++
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 99 +++++++++
 tb/tb_multicycle_controller.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// datapath select codes and the per-state Moore control word.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECR,
      EXECI,
      ALUWB,
      BRANCH,
      JAL,
      JALR,
      JALLINK,
      LUI
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMMEXT    = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       mem_req;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [2:0] imm_src;
   } ctrl_t;

   // Pure state decode; the mem_ready/Zero-qualified strobes are added in the top.
   function automatic ctrl_t state_ctrl(state_t s, logic op_b5);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_req    = 1'b1;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURESULT;
         end
         DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.imm_src   = IMM_B;
         end
         MEMADR: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_IMM;
            c.imm_src   = op_b5 ? IMM_S : IMM_I;
         end
         MEMREAD: begin
            c.mem_req = 1'b1;
            c.adr_src = 1'b1;
         end
         MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         MEMWRITE: begin
            c.mem_req   = 1'b1;
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         EXECR: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_RD2;
            c.alu_op    = ALUOP_FUNCT;
         end
         EXECI: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_IMM;
            c.imm_src   = IMM_I;
            c.alu_op    = ALUOP_FUNCT;
         end
         ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a  = SRCA_RD1;
            c.alu_src_b  = SRCB_RD2;
            c.alu_op     = ALUOP_SUB;
            c.result_src = RES_ALUOUT;
         end
         JAL: begin
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_IMM;
            c.imm_src    = IMM_J;
            c.result_src = RES_ALURESULT;
            c.pc_write   = 1'b1;
         end
         JALR: begin
            c.alu_src_a  = SRCA_RD1;
            c.alu_src_b  = SRCB_IMM;
            c.imm_src    = IMM_I;
            c.result_src = RES_ALURESULT;
            c.pc_write   = 1'b1;
         end
         JALLINK: begin
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURESULT;
            c.reg_write  = 1'b1;
         end
         LUI: begin
            c.result_src = RES_IMMEXT;
            c.imm_src    = IMM_U;
            c.reg_write  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and status in, control lines out.
interface multicycle_controller_if;
   logic [6:0] Op;
   logic [2:0] Func3;
   logic [6:0] Func7;
   logic       Zero;
   logic       Neg;
   logic       mem_ready;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       MemReq;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [2:0] ImmSrc;
   logic       IllegalOp;

   modport master (
      input  Op, Func3, Func7, Zero, Neg, mem_ready,
      output PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalOp
   );

   modport slave (
      output Op, Func3, Func7, Zero, Neg, mem_ready,
      input  PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalOp
   );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus Func3/Func7 to the shared ALU's operation code.
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] func3,
   input  logic       func7_b5,
   input  logic       op_b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (func3)
               // Func7[5] only means sub for R-type; for I-type it is immediate bits.
               3'b000:  alu_control = (op_b5 && func7_b5) ? ALU_SUB : ALU_ADD;
               3'b111:  alu_control = ALU_AND;
               3'b110:  alu_control = ALU_OR;
               3'b010:  alu_control = ALU_SLT;
               3'b100:  alu_control = ALU_XOR;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/writeback over
// a shared ALU and unified memory, stalling on mem_ready.
module multicycle_controller
   import rv_ctrl_pkg::*;
(
   input logic                    clk,
   input logic                    rst,
   multicycle_controller_if.master bus
);

   state_t     state;
   state_t     state_next;
   ctrl_t      ctrl_q;
   ctrl_t      ctrl_next;
   logic       illegal;
   logic       branch_taken;
   logic [1:0] alu_op;
   logic [2:0] alu_control;

   always_comb begin
      illegal    = 1'b0;
      state_next = state;
      case (state)
         FETCH:    if (bus.mem_ready) state_next = DECODE;
         DECODE: begin
            case (bus.Op)
               OP_LOAD, OP_STORE: state_next = MEMADR;
               OP_RTYPE:          state_next = EXECR;
               OP_ITYPE:          state_next = EXECI;
               OP_BRANCH:         state_next = BRANCH;
               OP_JAL:            state_next = JAL;
               OP_JALR:           state_next = JALR;
               OP_LUI:            state_next = LUI;
               default: begin
                  state_next = FETCH;
                  illegal    = 1'b1;
               end
            endcase
         end
         MEMADR:   state_next = bus.Op[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  if (bus.mem_ready) state_next = MEMWB;
         MEMWRITE: if (bus.mem_ready) state_next = FETCH;
         EXECR, EXECI: state_next = ALUWB;
         JAL, JALR:    state_next = JALLINK;
         default:      state_next = FETCH;
      endcase
      ctrl_next = state_ctrl(state_next, bus.Op[5]);
   end

   // Control word is registered from the next state, so ctrl_q always equals
   // the Moore decode of the current state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= FETCH;
         ctrl_q <= state_ctrl(FETCH, 1'b0);
      end else begin
         state  <= state_next;
         ctrl_q <= ctrl_next;
      end
   end

   always_comb begin
      case (bus.Func3)
         3'b000:  branch_taken = bus.Zero;
         3'b001:  branch_taken = !bus.Zero;
         3'b100:  branch_taken = bus.Neg;
         3'b101:  branch_taken = !bus.Neg;
         default: branch_taken = 1'b0;
      endcase
   end

   assign alu_op = rst ? ALUOP_ADD : ctrl_q.alu_op;

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .func3       (bus.Func3),
      .func7_b5    (bus.Func7[5]),
      .op_b5       (bus.Op[5]),
      .alu_control (alu_control)
   );

   // Reset forces every output low in the same cycle, so a reset landing on a
   // memory handshake never produces a partial write.
   assign bus.PCWrite    = !rst && (ctrl_q.pc_write
                                    || (state == FETCH  && bus.mem_ready)
                                    || (state == BRANCH && branch_taken));
   assign bus.IRWrite    = !rst && state == FETCH && bus.mem_ready;
   assign bus.IllegalOp  = !rst && illegal;
   assign bus.AdrSrc     = !rst && ctrl_q.adr_src;
   assign bus.MemWrite   = !rst && ctrl_q.mem_write;
   assign bus.MemReq     = !rst && ctrl_q.mem_req;
   assign bus.RegWrite   = !rst && ctrl_q.reg_write;
   assign bus.ResultSrc  = rst ? '0 : ctrl_q.result_src;
   assign bus.ALUSrcA    = rst ? '0 : ctrl_q.alu_src_a;
   assign bus.ALUSrcB    = rst ? '0 : ctrl_q.alu_src_b;
   assign bus.ImmSrc     = rst ? '0 : ctrl_q.imm_src;
   assign bus.ALUControl = alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each cycle pushes the expected
// control vector for the intended state, then pops and compares it before the edge.
module tb_multicycle_controller;

   typedef enum int {
      B_FETCH, B_DECODE, B_MEMADR, B_MEMREAD, B_MEMWB, B_MEMWRITE, B_EXECR,
      B_EXECI, B_ALUWB, B_BRANCH, B_JAL, B_JALR, B_JALLINK, B_LUI
   } bst_t;

   typedef struct {
      string       tag;
      logic [18:0] exp;
   } sb_t;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;
   sb_t  exp_q[$];

   multicycle_controller_if bus ();

   multicycle_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] exp_alu(input logic rtype);
      case (bus.Func3)
         3'b000:  return (rtype && bus.Func7[5]) ? 3'b001 : 3'b000;
         3'b111:  return 3'b010;
         3'b110:  return 3'b011;
         3'b010:  return 3'b100;
         3'b100:  return 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic exp_taken();
      case (bus.Func3)
         3'b000:  return bus.Zero;
         3'b001:  return !bus.Zero;
         3'b100:  return bus.Neg;
         3'b101:  return !bus.Neg;
         default: return 1'b0;
      endcase
   endfunction

   // Expected output vector for a given state with the currently driven inputs.
   function automatic logic [18:0] exp_out(input bst_t st);
      logic       pcw, adr, mw, mrq, irw, rw, ill;
      logic [1:0] res, sa, sb;
      logic [2:0] alu, imm;
      {pcw, adr, mw, mrq, irw, rw, ill} = '0;
      res = '0; sa = '0; sb = '0; alu = '0; imm = '0;
      if (!rst) begin
         case (st)
            B_FETCH: begin
               mrq = 1'b1; sb = 2'b10; res = 2'b10;
               irw = bus.mem_ready; pcw = bus.mem_ready;
            end
            B_DECODE: begin
               sa = 2'b01; sb = 2'b01; imm = 3'b010;
               ill = !(bus.Op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111});
            end
            B_MEMADR: begin
               sa = 2'b10; sb = 2'b01;
               imm = (bus.Op == 7'b0100011) ? 3'b001 : 3'b000;
            end
            B_MEMREAD:  begin mrq = 1'b1; adr = 1'b1; end
            B_MEMWB:    begin res = 2'b01; rw = 1'b1; end
            B_MEMWRITE: begin mrq = 1'b1; adr = 1'b1; mw = 1'b1; end
            B_EXECR:    begin sa = 2'b10; sb = 2'b00; alu = exp_alu(1'b1); end
            B_EXECI:    begin sa = 2'b10; sb = 2'b01; alu = exp_alu(1'b0); end
            B_ALUWB:    begin res = 2'b00; rw = 1'b1; end
            B_BRANCH:   begin sa = 2'b10; sb = 2'b00; alu = 3'b001; pcw = exp_taken(); end
            B_JAL:      begin sa = 2'b01; sb = 2'b01; imm = 3'b011; res = 2'b10; pcw = 1'b1; end
            B_JALR:     begin sa = 2'b10; sb = 2'b01; imm = 3'b000; res = 2'b10; pcw = 1'b1; end
            B_JALLINK:  begin sa = 2'b01; sb = 2'b10; res = 2'b10; rw = 1'b1; end
            B_LUI:      begin res = 2'b11; imm = 3'b100; rw = 1'b1; end
            default: ;
         endcase
      end
      return {pcw, adr, mw, mrq, irw, rw, res, sa, sb, alu, imm, ill};
   endfunction

   function automatic logic [18:0] observed();
      return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.MemReq, bus.IRWrite,
              bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
              bus.ALUControl, bus.ImmSrc, bus.IllegalOp};
   endfunction

   // Called right after a falling edge with inputs set; samples 1 time unit before the rising edge.
   task automatic step(input string tag, input bst_t st);
      sb_t         e;
      logic [18:0] obs;
      exp_q.push_back('{tag, exp_out(st)});
      #4;
      obs = observed();
      e   = exp_q.pop_front();
      n_assert++;
      assert (obs === e.exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
      @(negedge clk);
   endtask

   task automatic instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7);
      bus.Op = op; bus.Func3 = f3; bus.Func7 = f7; bus.mem_ready = 1'b1;
      step({tag, "_fetch"}, B_FETCH);
      step({tag, "_decode"}, B_DECODE);
   endtask

   logic [16:0] alu_tab [6] = '{
      {7'b0110011, 3'b111, 7'b0000000},
      {7'b0110011, 3'b110, 7'b0000000},
      {7'b0110011, 3'b010, 7'b0000000},
      {7'b0110011, 3'b001, 7'b0100000},
      {7'b0010011, 3'b100, 7'b0000000},
      {7'b0010011, 3'b000, 7'b0100000}
   };

   initial begin
      rst = 1'b1;
      bus.mem_ready = 1'b0; bus.Op = '0; bus.Func3 = '0; bus.Func7 = '0;
      bus.Zero = 1'b0; bus.Neg = 1'b0;
      step("rst_hold", B_FETCH);
      bus.mem_ready = 1'b1;
      step("rst_with_ready", B_FETCH);
      rst = 1'b0; bus.mem_ready = 1'b0;
      step("fetch_wait0", B_FETCH);
      step("fetch_wait1", B_FETCH);

      instr("add", 7'b0110011, 3'b000, 7'b0000000);
      step("add_exec", B_EXECR);
      step("add_wb", B_ALUWB);
      instr("sub", 7'b0110011, 3'b000, 7'b0100000);
      step("sub_exec", B_EXECR);
      step("sub_wb", B_ALUWB);

      instr("lw", 7'b0000011, 3'b010, 7'b0000000);
      step("lw_adr", B_MEMADR);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("lw_hold", B_MEMREAD);
      bus.mem_ready = 1'b1;
      step("lw_ready", B_MEMREAD);
      step("lw_wb", B_MEMWB);

      instr("sw", 7'b0100011, 3'b010, 7'b0000000);
      step("sw_adr", B_MEMADR);
      bus.mem_ready = 1'b0;
      step("sw_hold", B_MEMWRITE);
      bus.mem_ready = 1'b1;
      step("sw_ready", B_MEMWRITE);

      instr("beq_t", 7'b1100011, 3'b000, 7'b0000000);
      bus.Zero = 1'b1; step("beq_taken", B_BRANCH);
      instr("beq_n", 7'b1100011, 3'b000, 7'b0000000);
      bus.Zero = 1'b0; step("beq_not", B_BRANCH);
      instr("bge", 7'b1100011, 3'b101, 7'b0000000);
      bus.Neg = 1'b1; step("bge_neg", B_BRANCH);
      instr("blt", 7'b1100011, 3'b100, 7'b0000000);
      step("blt_neg", B_BRANCH);
      instr("bltu", 7'b1100011, 3'b110, 7'b0000000);
      step("bltu_nowrite", B_BRANCH);
      bus.Neg = 1'b0;

      instr("jal", 7'b1101111, 3'b000, 7'b0000000);
      step("jal_target", B_JAL);
      step("jal_link", B_JALLINK);
      instr("jalr", 7'b1100111, 3'b000, 7'b0000000);
      step("jalr_target", B_JALR);
      step("jalr_link", B_JALLINK);
      instr("lui", 7'b0110111, 3'b000, 7'b0000000);
      step("lui_wb", B_LUI);

      foreach (alu_tab[i]) begin
         logic [16:0] t;
         t = alu_tab[i];
         instr("alu", t[16:10], t[9:7], t[6:0]);
         step("alu_exec", (t[16:10] == 7'b0110011) ? B_EXECR : B_EXECI);
         step("alu_wb", B_ALUWB);
      end

      instr("illegal", 7'b1111111, 3'b000, 7'b0000000);
      bus.mem_ready = 1'b0;
      step("illegal_to_fetch", B_FETCH);

      instr("sw_rst", 7'b0100011, 3'b010, 7'b0000000);
      step("sw_rst_adr", B_MEMADR);
      bus.mem_ready = 1'b0;
      step("sw_rst_hold", B_MEMWRITE);
      rst = 1'b1;
      step("sw_rst_assert", B_FETCH);
      rst = 1'b0;
      step("sw_rst_fetch", B_FETCH);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
